// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave frame controller: {cmd, payload} to RAM side, RAM read data out on MISO.
// Optional trailing even-parity bit enabled by defining SPI_FRAME_PARITY_EN.
module spi_slave_frame_ctrl #(
    parameter int unsigned DATA_W      = 8,
    parameter bit          LSB_FIRST   = 1'b0,
    parameter int unsigned RD_WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned WAIT_W = $clog2(RD_WAIT_MAX + 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_CMD,
        RX_PAYLOAD,
        WAIT_TX,
        TX_DATA,
        DONE
`ifdef SPI_FRAME_PARITY_EN
        , RX_PARITY
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [DATA_W-1:0]   pay_q, pay_d, pay_next;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic                miso_d;
    logic [DATA_W+1:0]   rx_data_d;
    logic                rx_valid_d;
    logic                frame_err_d;

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            wait_q    <= '0;
            cmd_q     <= '0;
            pay_q     <= '0;
            tx_sh_q   <= '0;
            MISO      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            wait_q    <= wait_d;
            cmd_q     <= cmd_d;
            pay_q     <= pay_d;
            tx_sh_q   <= tx_sh_d;
            MISO      <= miso_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        wait_d      = wait_q;
        cmd_d       = cmd_q;
        pay_d       = pay_q;
        tx_sh_d     = tx_sh_q;
        miso_d      = MISO;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        pay_next    = LSB_FIRST ? {MOSI, pay_q[DATA_W-1:1]}
                                : {pay_q[DATA_W-2:0], MOSI};

        if (SS_n) begin
            // Deselect always wins, including over a last-bit or parity edge
            state_d     = IDLE;
            bit_cnt_d   = '0;
            wait_d      = '0;
            miso_d      = 1'b0;
            frame_err_d = (state_q != IDLE) && (state_q != DONE);
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_d     = {MOSI, 1'b0};
                    bit_cnt_d = '0;
                    state_d   = RX_CMD;
                end
                RX_CMD: begin
                    cmd_d   = {cmd_q[1], MOSI};
                    state_d = RX_PAYLOAD;
                end
                RX_PAYLOAD: begin
                    pay_d = pay_next;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SPI_FRAME_PARITY_EN
                        state_d = RX_PARITY;
`else
                        rx_data_d  = {cmd_q, pay_next};
                        rx_valid_d = 1'b1;
                        wait_d     = '0;
                        state_d    = (cmd_q == 2'b11) ? WAIT_TX : DONE;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
`ifdef SPI_FRAME_PARITY_EN
                RX_PARITY: begin
                    if (^{cmd_q, pay_q, MOSI}) begin
                        frame_err_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rx_data_d  = {cmd_q, pay_q};
                        rx_valid_d = 1'b1;
                        wait_d     = '0;
                        state_d    = (cmd_q == 2'b11) ? WAIT_TX : DONE;
                    end
                end
`endif
                WAIT_TX: begin
                    if (tx_valid) begin
                        // First bit goes out on the load edge; the rest stay queued
                        miso_d    = LSB_FIRST ? tx_data[0] : tx_data[DATA_W-1];
                        tx_sh_d   = LSB_FIRST ? (tx_data >> 1) : (tx_data << 1);
                        bit_cnt_d = '0;
                        wait_d    = '0;
                        state_d   = TX_DATA;
                    end else if (wait_q == WAIT_LAST) begin
                        frame_err_d = 1'b1;
                        miso_d      = 1'b0;
                        wait_d      = '0;
                        state_d     = DONE;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        miso_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        miso_d    = LSB_FIRST ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
                        tx_sh_d   = LSB_FIRST ? (tx_sh_q >> 1) : (tx_sh_q << 1);
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

endmodule
